// File: rtl/ldl_pend_sched_if.sv
// Request/consumer bus of the pending-event scheduler.
// The slave side is the scheduler; the master side is whoever drives requests and consumes indices.
interface ldl_pend_sched_if #(
    parameter int WIDTH = 4
) ();
    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [WIDTH-1:0] req;
    logic [WIDTH-1:0] mask;
    logic             flush;
    logic             out_valid;
    logic [IW-1:0]    out_idx;
    logic             out_ready;
    logic [WIDTH-1:0] pend;
    logic [WIDTH-1:0] ovf;
    logic             ovf_clr;

    modport master (
        output req, mask, flush, out_ready, ovf_clr,
        input  out_valid, out_idx, pend, ovf
    );

    modport slave (
        input  req, mask, flush, out_ready, ovf_clr,
        output out_valid, out_idx, pend, ovf
    );
endinterface

// File: rtl/ldl_pend_sched.sv
// Sticky pending-event scheduler: latches request pulses, picks one eligible index per
// transfer (lowest-first or round-robin) and presents it on a registered valid/ready stage.
module ldl_pend_sched #(
    parameter int WIDTH = 4,
    parameter int RR    = 0
) (
    input  logic              clk,
    input  logic              rst,
    ldl_pend_sched_if.slave   bus
);
    localparam int               IW  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [WIDTH-1:0] pend_q, pend_d;
    logic [WIDTH-1:0] ovf_q, ovf_d;
    logic             vld_q, vld_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [IW-1:0]    ptr_q, ptr_d;

    logic [WIDTH-1:0] elig, clr_vec, ovf_set;
    logic [IW-1:0]    sel, sel_lo, sel_hi;
    logic             hit_hi, load;

    assign elig = pend_q & ~bus.mask;

    // Descending scan so the last hit is the lowest index; sel_hi only sees indices past ptr.
    always_comb begin
        sel_lo = '0;
        sel_hi = '0;
        hit_hi = 1'b0;
        for (int i = WIDTH-1; i >= 0; i--) begin
            if (elig[i]) sel_lo = i[IW-1:0];
            if (elig[i] && (i > int'(ptr_q))) begin
                sel_hi = i[IW-1:0];
                hit_hi = 1'b1;
            end
        end
        sel = ((RR != 0) && hit_hi) ? sel_hi : sel_lo;
    end

    always_comb begin
        load    = (|elig) && (!vld_q || bus.out_ready);
        clr_vec = (load && !bus.flush) ? (ONE << sel) : '0;

        // A request landing on a bit being served re-arms it rather than overflowing.
        pend_d  = bus.flush ? bus.req : ((pend_q & ~clr_vec) | bus.req);
        ovf_set = bus.flush ? '0 : (bus.req & pend_q & ~clr_vec);
        ovf_d   = ovf_set | (ovf_q & ~{WIDTH{bus.ovf_clr}});

        vld_d = vld_q;
        idx_d = idx_q;
        ptr_d = ptr_q;
        if (bus.flush) begin
            vld_d = 1'b0;
        end else if (load) begin
            vld_d = 1'b1;
            idx_d = sel;
            if (RR != 0) ptr_d = sel;
        end else if (vld_q && bus.out_ready) begin
            vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_q <= '0;
            ovf_q  <= '0;
            vld_q  <= 1'b0;
            idx_q  <= '0;
            ptr_q  <= IW'(WIDTH-1);
        end else begin
            pend_q <= pend_d;
            ovf_q  <= ovf_d;
            vld_q  <= vld_d;
            idx_q  <= idx_d;
            ptr_q  <= ptr_d;
        end
    end

    assign bus.pend      = pend_q;
    assign bus.ovf       = ovf_q;
    assign bus.out_valid = vld_q;
    assign bus.out_idx   = idx_q;
endmodule

// File: doc/ldl_pend_sched.md
Name: ldl_pend_sched

Overview:
- Sticky pending-event scheduler that sits directly upstream of the priority encoder.
- Captures single-cycle request pulses into a pending vector and selects one pending index per transfer, using lowest-index-wins priority (optionally round-robin).
- Presents the selected index on a registered valid/ready output and clears the served pending bit.
- Typical use: interrupt/event collection feeding a single consumer port.

Parameters:
- WIDTH, 4, number of request lines; legal range is WIDTH >= 2.
- RR, 0, 0 = fixed priority (lowest index wins); 1 = round-robin starting after the last issued index.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- req  input  WIDTH  request pulses; req[i]=1 sets pend[i].
- mask  input  WIDTH  mask[i]=1 makes index i ineligible for selection; the pending bit is held.
- flush  input  1  synchronous clear of all pending bits and the output stage.
- out_valid  output  1  out_idx holds a valid index.
- out_idx  output  $clog2(WIDTH)  selected index.
- out_ready  input  1  consumer accepts out_idx when out_valid=1 and out_ready=1.
- pend  output  WIDTH  current pending vector (registered).
- ovf  output  WIDTH  sticky overflow per index.
- ovf_clr  input  1  synchronous clear of ovf.

Behaviour:
- Reset: pend=0, ovf=0, out_valid=0, out_idx=0, RR pointer=WIDTH-1.
- Reset applies asynchronously; all in-flight state is discarded, including any mid-handshake index.
- Eligible vector: elig = pend & ~mask.
- Fixed mode (RR=0): select the lowest set bit of elig.
- Round-robin mode (RR=1):
  - Select the lowest set bit of elig with index > ptr.
  - If no such bit exists, select the lowest set bit of elig (wrap-around).
  - ptr <= selected index on every load.
- Load condition: load = (elig != 0) && (!out_valid || out_ready).
- On load:
  - out_valid <= 1, out_idx <= selected index.
  - The selected pend bit is cleared on the same edge.
- No load and out_valid && out_ready: out_valid <= 0; out_idx holds its last value.
- out_valid && !out_ready: out_idx and out_valid are held stable, and no pend bit is consumed.
- pend[i] next state = (pend[i] & ~clear_i) | req[i]. A req on the same cycle its bit is cleared leaves pend[i]=1.
- ovf[i] <= 1 when req[i]=1, pend[i]=1 and bit i is not being cleared that cycle.
  - ovf_clr clears ovf, but a same-cycle overflow event wins.
  - A req for an index currently held in the output stage but not pending is not an overflow.
- Latency:
  - req at edge N gives pend at N+1.
  - out_valid at N+2 when the output stage is free.
  - Sustained throughput is 1 index per cycle with out_ready=1.
- Mask changes take effect on the next load decision (the same cycle's combinational select). A masked index already in the output stage is still delivered.
- flush:
  - pend <= req (requests arriving in the flush cycle are kept).
  - out_valid <= 0.
  - ptr and ovf are unchanged.
  - flush overrides load.
- Width rule: out_idx is the truncated binary index, width $clog2(WIDTH); non-power-of-2 WIDTH is legal.

Test Plan:
1. WIDTH=4, RR=0, reset, then pulse req=4'b1010 for one cycle with out_ready=1.
   -> pend=1010 next cycle; out_idx=1 then out_idx=3 on consecutive cycles; pend=0000 afterwards; ovf=0.
2. RR=1, hold req=4'b1111 for one cycle, out_ready=1.
   -> issue order 0,1,2,3.
   -> Then pulse req=4'b0101 -> order 0,2.
   -> Then pulse req=4'b0101 again -> order 0,2 (ptr=2, wrap to 0 first).
3. out_ready=0 with out_idx=2 valid; pulse req[2] twice on separate cycles.
   -> first pulse sets pend[2] with no ovf; second pulse sets ovf[2]=1.
   -> out_idx stays 2 throughout; raising out_ready delivers 2, then 2 again.
4. pend=4'b0011, mask=4'b0001.
   -> only index 1 issued; pend=0001 held.
   -> Clearing mask issues 0 on the following transfer.
5. Async rst asserted mid-transfer (out_valid=1, pend=0110, ovf=0100).
   -> outputs immediately 0: out_valid=0, pend=0, ovf=0.
   -> After release, an RR=1 pick starts from index 0.
6. flush with pend=1111 and req=4'b0010 in the same cycle.
   -> out_valid=0 and pend=0010 next cycle; out_idx=1 one cycle later.
